// File: rtl/apb_mem_slave.sv
// APB completer with a byte-wide memory, read-only upper region, out-of-range errors and optional wait states.
// Wait states are enabled by defining APB_SLV_WAIT_EN; otherwise every transfer completes in its first access cycle.
module apb_mem_slave #(
  parameter int          DEPTH       = 192,
  parameter logic [7:0]  RO_BASE     = 8'hA0,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [8:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

`ifdef APB_SLV_WAIT_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
`else
  localparam logic [3:0] WAIT_LOAD = 4'd0;
  logic unused_wait;
  assign unused_wait = ^32'(WAIT_CYCLES);
`endif

  // PADDR[8] selects this slave in the master and carries no meaning here.
  logic unused_addr;
  assign unused_addr = PADDR[8];

  logic [7:0] mem [DEPTH];

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] prdata_q, prdata_d;
  logic       write_q, write_d;
  logic       err_q, err_d;
  logic       setup_err;
  logic       ready;
  logic       mem_we;

  assign setup_err = ({1'b0, PADDR[7:0]} >= DEPTH_L) | (PWRITE & (PADDR[7:0] >= RO_BASE));
  assign ready     = (state_q == ACCESS) && (cnt_q == 4'd0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    prdata_d = prdata_q;
    write_d  = write_q;
    err_d    = err_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        // PSEL with PENABLE already high here is a protocol violation and is ignored.
        if (PSEL && !PENABLE) begin
          addr_d   = PADDR[7:0];
          write_d  = PWRITE;
          wdata_d  = PWDATA;
          err_d    = setup_err;
          cnt_d    = WAIT_LOAD;
          prdata_d = (!PWRITE && !setup_err) ? mem[PADDR[7:0]] : 8'h00;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d  = IDLE;
          cnt_d    = 4'd0;
          prdata_d = 8'h00;
        end else if (PENABLE) begin
          if (ready) begin
            mem_we  = write_q & ~err_q;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      prdata_q <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prdata_q <= prdata_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    write_q <= write_d;
  end

  // Reset during the completion edge suppresses the commit.
  always_ff @(posedge CLK) begin
    if (RST_N && mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = ready;
  assign PSLVERR = ready & err_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Randomized and directed bench for apb_mem_slave against a transaction-level memory model.
module tb_apb_mem_slave;

  localparam int         DEPTH   = 192;
  localparam logic [7:0] RO_BASE = 8'hA0;
  localparam int         TB_WAIT = 2;
`ifdef APB_SLV_WAIT_EN
  localparam int EXP_WAIT = TB_WAIT;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       PSEL = 1'b0;
  logic       PENABLE = 1'b0;
  logic       PWRITE = 1'b0;
  logic [8:0] PADDR = '0;
  logic [7:0] PWDATA = '0;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  apb_mem_slave #(.DEPTH(DEPTH), .RO_BASE(RO_BASE), .WAIT_CYCLES(TB_WAIT)) dut (
    .CLK(CLK), .RST_N(RST_N), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [256];
  bit         known   [256];
  logic [7:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: normal, 1: PSEL dropped after setup, 2: reset pulsed in access
  task automatic xfer(input bit w, input logic [8:0] a, input logic [7:0] d,
                      input int hold, input int mode);
    logic [7:0] a8;
    bit         exp_err, rd_known, done;
    logic [7:0] exp_rd;
    int         waits;
    a8       = a[7:0];
    exp_err  = (int'(a8) >= DEPTH) || (w && a8 >= RO_BASE);
    rd_known = w || exp_err || known[a8];
    exp_rd   = (!w && !exp_err) ? ref_mem[a8] : 8'h00;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    @(posedge CLK); #1;
    if (mode == 1) begin
      PSEL = 1'b0;
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("abort_pready", 32'(PREADY), 32'd0);
      chk("abort_prdata", 32'(PRDATA), 32'd0);
      chk("abort_pslverr", 32'(PSLVERR), 32'd0);
      last_rd = 8'h00;
      @(posedge CLK); #1;
      return;
    end
    if (mode == 2) begin
      PENABLE = 1'b1; RST_N = 1'b0;
      @(posedge CLK); #1;
      RST_N = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge CLK);
      chk("midrst_pready", 32'(PREADY), 32'd0);
      chk("midrst_prdata", 32'(PRDATA), 32'd0);
      last_rd = 8'h00;
      @(posedge CLK); #1;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      chk("hold_pready", 32'(PREADY), 32'(EXP_WAIT == 0));
      chk("hold_pslverr", 32'(PSLVERR), 32'(EXP_WAIT == 0 && exp_err));
      @(posedge CLK); #1;
    end
    PENABLE = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      if (rd_known) chk("access_prdata", 32'(PRDATA), 32'(exp_rd));
      if (PREADY === 1'b1) begin
        done = 1'b1;
        chk("pslverr", 32'(PSLVERR), 32'(exp_err));
      end else begin
        waits++;
        chk("wait_pslverr", 32'(PSLVERR), 32'd0);
      end
      @(posedge CLK); #1;
    end
    chk("completed", 32'(done), 32'd1);
    chk("wait_states", 32'(waits), 32'(EXP_WAIT));
    if (w && !exp_err) begin
      ref_mem[a8] = d;
      known[a8]   = 1'b1;
    end
    last_rd = rd_known ? exp_rd : PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    @(negedge CLK);
    chk({tag, "_idle_pready"}, 32'(PREADY), 32'd0);
    chk({tag, "_held_prdata"}, 32'(PRDATA), 32'(last_rd));
    @(posedge CLK); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ro_old;
    for (int i = 0; i < 256; i++) known[i] = 1'b0;

    // Reset with an access attempted underneath it.
    RST_N = 1'b0; PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 9'h010;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_prdata", 32'(PRDATA), 32'd0);
    @(posedge CLK); #1;
    PSEL = 1'b0; RST_N = 1'b1;
    @(negedge CLK);
    chk("rel_pready", 32'(PREADY), 32'd0);
    chk("rel_prdata", 32'(PRDATA), 32'd0);
    chk("rel_pslverr", 32'(PSLVERR), 32'd0);
    @(posedge CLK); #1;

    // Directed write/read.
    xfer(1'b1, 9'h010, 8'h5A, 0, 0);
    xfer(1'b0, 9'h010, 8'h00, 0, 0);
    chk("rd_5a", 32'(last_rd), 32'h5A);
    idle_check("rd010");

    // Fill the writable region, back to back.
    for (int a = 0; a < int'(RO_BASE); a++) xfer(1'b1, 9'(a), 8'($urandom), 0, 0);

    // Read-only protection.
    xfer(1'b0, 9'h0A5, 8'h00, 0, 0);
    ro_old = PRDATA;
    ref_mem[8'hA5] = ro_old;
    known[8'hA5]   = 1'b1;
    xfer(1'b1, 9'h0A5, 8'hFF, 0, 0);
    xfer(1'b0, 9'h0A5, 8'h00, 0, 0);
    idle_check("ro");

    // Out of range read.
    xfer(1'b0, 9'h0C3, 8'h00, 0, 0);
    idle_check("oor");

    // Bit-8 alias.
    xfer(1'b1, 9'h110, 8'h33, 0, 0);
    xfer(1'b0, 9'h010, 8'h00, 0, 0);
    chk("alias_rd", 32'(last_rd), 32'h33);

    // Abort by PSEL drop, then mid-transfer reset; neither may write.
    xfer(1'b1, 9'h020, 8'h77, 0, 1);
    xfer(1'b0, 9'h020, 8'h00, 0, 0);
    xfer(1'b1, 9'h030, ~ref_mem[8'h30], 0, 2);
    xfer(1'b0, 9'h030, 8'h00, 0, 0);

    // PENABLE held low in access.
    xfer(1'b1, 9'h040, 8'hC3, 2, 0);
    xfer(1'b0, 9'h040, 8'h00, 1, 0);

    // Protocol violation: PSEL and PENABLE together in IDLE.
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 9'h050; PWDATA = 8'hEE;
    @(posedge CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    idle_check("violation");
    xfer(1'b0, 9'h050, 8'h00, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 120; n++) begin
      logic [8:0] ra;
      ra = 9'($urandom_range(0, 511));
      xfer(1'($urandom), ra, 8'($urandom), ($urandom_range(0, 5) == 0) ? 1 : 0,
           ($urandom_range(0, 9) == 0) ? 1 : 0);
      if ($urandom_range(0, 3) == 0) idle_check("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- APB completer holding a byte-wide register/memory array.
- Sits directly downstream of the team's APB master and serves one PSELx leg of it, so the APB_MASTER PSEL1 or PSEL2 output drives this block's PSEL.
- Decodes PADDR[7:0] only; PADDR[8] is the master's slave-select bit and is ignored here.
- Provides wait states, read-only-region protection and out-of-range error reporting via PSLVERR.

Parameters:
- DEPTH, 192: number of implemented bytes. Addresses >= DEPTH are out of range.
- RO_BASE, 8'hA0: addresses >= RO_BASE and < DEPTH are read-only.
- WAIT_CYCLES, 2: wait states inserted per transfer. Range 0..15. Used only when APB_SLV_WAIT_EN is defined.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  reset; synchronous, active-low
- PSEL  in  1  slave select from master
- PENABLE  in  1  access phase strobe (master PEN)
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  9  address; bits [7:0] decoded, bit 8 ignored
- PWDATA  in  8  write data
- PRDATA  out  8  read data
- PREADY  out  1  transfer completes on a rising edge where PSEL & PENABLE & PREADY
- PSLVERR  out  1  error response, valid only while PREADY=1

Behaviour:
- Reset: RST_N is synchronous, active-low. Sampled at the rising edge.
  - Outputs after reset: PRDATA=0, PREADY=0, PSLVERR=0, state=IDLE, wait counter=0.
  - Memory contents are not reset.
  - Reset asserted mid-transfer aborts it. No write commits. The next cycle is IDLE.
- States: IDLE, ACCESS.
- IDLE:
  - On an edge with PSEL=1 and PENABLE=0 (setup phase), the block:
    - latches addr=PADDR[7:0], write=PWRITE and wdata=PWDATA;
    - computes err = (addr>=DEPTH) | (write & addr>=RO_BASE);
    - loads the wait counter;
    - loads PRDATA <= (read & !err) ? mem[addr] : 8'h00;
    - moves to ACCESS.
  - PSEL=1 with PENABLE=1 while in IDLE is a protocol violation. It is ignored and the state stays IDLE.
- ACCESS:
  - PREADY = (wait counter==0), combinational from registers only.
  - While the counter is nonzero, it decrements each cycle.
  - Completion edge (PSEL & PENABLE & PREADY):
    - if write & !err, mem[addr] <= wdata;
    - state goes to IDLE.
  - PSEL dropped in ACCESS: abort to IDLE, no write, PRDATA cleared to 0.
  - PENABLE=0 with PSEL=1 in ACCESS: hold state and counter.
- PSLVERR = ACCESS & PREADY & err. It is 0 at all other times.
- Latency:
  - Zero-wait transfer = 2 cycles (setup + access).
  - Back-to-back transfers: the master's setup cycle coincides with slave IDLE, so there is no dead cycle.
- Read data is the pre-write value; there is no read-during-write hazard because only one transfer is in flight.
- PRDATA holds its value after completion until the next setup edge or an abort.

Optional Feature:
- APB_SLV_WAIT_EN defined: the wait counter loads WAIT_CYCLES at the setup edge. PREADY rises after WAIT_CYCLES access cycles.
- Undefined: the counter always loads 0. PREADY=1 in the first access cycle. The WAIT_CYCLES parameter is unused.

Test Plan:
- Reset check: hold RST_N=0 for 3 cycles, then release -> PRDATA=8'h00, PREADY=0, PSLVERR=0. No response to an access started during reset.
- Write then read, macro undefined:
  - stimulus: write 8'h5A to PADDR=9'h010, then read 9'h010;
  - expected: each transfer completes in 2 cycles, PREADY=1 in the first access cycle, PRDATA=8'h5A, PSLVERR=0.
- Wait states, APB_SLV_WAIT_EN with WAIT_CYCLES=2:
  - stimulus: read 9'h010;
  - expected: PREADY=0 for 2 access cycles, then 1 in the third, PRDATA=8'h5A throughout access.
- Error cases:
  - write 8'hFF to 9'h0A5 (read-only) -> PSLVERR=1 at completion, and a later read of 9'h0A5 returns the old contents;
  - read 9'h0C3 (out of range) -> PSLVERR=1, PRDATA=8'h00.
- Bit-8 alias: write 8'h33 via PADDR=9'h110, then read 9'h010 -> PRDATA=8'h33.
- Abort:
  - stimulus: with WAIT_CYCLES=3, drop PSEL during the wait of a write of 8'h77 to 9'h020;
  - expected: state returns to IDLE, and a subsequent read of 9'h020 returns the prior value.
